instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Producer-side counterpart of the opcode decoder: turns mnemonic-level requests
//  (op index + register/shamt/imm fields) into 32-bit instruction words, using the
//  same 6-bit opcode map the decoder consumes.
//  Words are buffered in a small FIFO and drained over a valid/ready port into
//  instruction memory or a fetch stage. Illegal op indices are dropped and counted.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of 2, >= 2
//  ERR_W  8  width of saturating illegal-request counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      request present
//  in_ready   out  1      encoder can accept (= !full)
//  in_op      in   4      op index: 0 ADD,1 SUB,2 INC,3 DEC,4 AND,5 OR,6 XOR,7 NOT,
//                         8 SLL,9 SRL,10 ADDI,11 SUBI,12 LW,13 SW; 14-15 illegal
//  in_rs      in   5      source A register
//  in_rt      in   5      source B / I-type target register
//  in_rd      in   5      R-type destination register
//  in_shamt   in   5      shift amount (used by SLL/SRL only)
//  in_imm     in   16     immediate / offset (I-type only)
//  out_valid  out  1      FIFO head valid (= !empty)
//  out_ready  in   1      consumer takes head
//  out_instr  out  32     FIFO head word
//  level      out  $clog2(DEPTH)+1  current occupancy
//  err_pulse  out  1      one-cycle pulse when an illegal request is accepted
//  err_cnt    out  ERR_W  illegal requests accepted, saturating at all-ones
// BEHAVIOUR
//  Reset (async, rst_n=0): pointers and level=0 (out_valid=0, in_ready=1),
//   err_pulse=0, err_cnt=0; out_instr=0 while empty. Reset mid-stream drops all entries.
//  Opcodes: ADD 000001, SUB 000010, INC 000011, DEC 000100, AND 000101, OR 000110,
//   XOR 000111, NOT 001000, SLL 001001, SRL 001010, ADDI 001011, SUBI 001100,
//   LW 100010, SW 100100.
//  R-type (idx 0-9): {opc,rs,rt,rd,shamt',6'b0}; shamt'=in_shamt for SLL/SRL, else 0.
//  I-type (idx 10-13): {opc,rs,rt,imm}. Fields are passed through unmodified.
//  Accept: in_valid & in_ready at a rising edge. Legal op -> encoded word written
//   at that edge; out_valid high from the next cycle (latency 1). No empty bypass.
//  Illegal op (14/15): consumes the handshake like a legal request; nothing written;
//   err_pulse=1 for the following cycle; err_cnt += 1 unless already all-ones.
//  Pop: out_valid & out_ready at an edge advances the head; out_instr is the head
//   entry, stable while out_valid & !out_ready.
//  Simultaneous push+pop (not full, not empty): level unchanged, order preserved.
//  Full: in_ready=0 even if a pop occurs in the same cycle (no full pass-through).
//  Empty: out_ready ignored. Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
//  in_* inputs are sampled only on an accepted edge; no X propagates when in_valid=0.
// TESTING
//  1 ADD rd=1 rs=2 rt=3, shamt=7 -> out_instr=0x04430800 one cycle later (shamt zeroed)
//  2 SLL rd=1 rs=0 rt=2 shamt=3 -> 0x240208C0; SW rs=4 rt=5 imm=0x0010 -> 0x90850010
//  3 out_ready=0, push DEPTH words -> level=DEPTH, in_ready=0; extra in_valid is not
//    accepted; then drain -> words in push order, level=0, out_valid=0
//  4 steady push+pop every cycle over 3*DEPTH words -> level constant, order kept
//    across pointer wrap
//  5 in_op=15 -> no FIFO write, err_pulse for 1 cycle, err_cnt=1; 300 illegal
//    requests -> err_cnt=255 (saturated)
//  6 rst_n low while level=3 (mid-pop) -> immediately level=0, out_valid=0,
//    err_cnt=0; first push after release -> correct word, level=1

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: maps op-index requests to 32-bit instruction words and
// buffers them in a DEPTH-entry FIFO drained over a valid/ready port.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_op,
  input  logic [4:0]                 in_rs,
  input  logic [4:0]                 in_rt,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_shamt,
  input  logic [15:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err_pulse,
  output logic [ERR_W-1:0]           err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_INC  = 4'd2,
    OP_DEC  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOT  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_ADDI = 4'd10,
    OP_SUBI = 4'd11,
    OP_LW   = 4'd12,
    OP_SW   = 4'd13
  } op_e;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [5:0]       opc;
  logic             legal;
  logic             r_type;
  logic             use_shamt;
  logic [31:0]      encoded;
  logic             accept;
  logic             push;
  logic             pop;

  // Opcode map shared with the decoder; anything outside it is an illegal request.
  always_comb begin
    opc       = 6'b000000;
    legal     = 1'b1;
    r_type    = 1'b1;
    use_shamt = 1'b0;
    case (in_op)
      OP_ADD:  opc = 6'b000001;
      OP_SUB:  opc = 6'b000010;
      OP_INC:  opc = 6'b000011;
      OP_DEC:  opc = 6'b000100;
      OP_AND:  opc = 6'b000101;
      OP_OR:   opc = 6'b000110;
      OP_XOR:  opc = 6'b000111;
      OP_NOT:  opc = 6'b001000;
      OP_SLL: begin
        opc       = 6'b001001;
        use_shamt = 1'b1;
      end
      OP_SRL: begin
        opc       = 6'b001010;
        use_shamt = 1'b1;
      end
      OP_ADDI: begin
        opc    = 6'b001011;
        r_type = 1'b0;
      end
      OP_SUBI: begin
        opc    = 6'b001100;
        r_type = 1'b0;
      end
      OP_LW: begin
        opc    = 6'b100010;
        r_type = 1'b0;
      end
      OP_SW: begin
        opc    = 6'b100100;
        r_type = 1'b0;
      end
      default: begin
        legal  = 1'b0;
        r_type = 1'b0;
      end
    endcase
  end

  always_comb begin
    encoded = 32'h0;
    if (r_type)
      encoded = {opc, in_rs, in_rt, in_rd, (use_shamt ? in_shamt : 5'd0), 6'b000000};
    else
      encoded = {opc, in_rs, in_rt, in_imm};
  end

  assign in_ready  = (level != FULL_LVL);
  assign out_valid = (level != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign pop       = out_valid & out_ready;
  assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= encoded;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Illegal requests still complete the handshake; they only bump the saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= accept & ~legal;
      if (accept && !legal && !(&err_cnt))
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table vectors, hand-written corner
// sequences and random traffic against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int ERR_W = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [2:0]  level;
  logic        err_pulse;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_q[$];
  int          model_err;
  logic        model_pulse;

  int opc_tab[14] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 34, 36};

  typedef struct {
    int op; int rs; int rt; int rd; int sh; int imm;
    logic [31:0] word;
  } vec_t;
  vec_t vecs[7];

  instr_encoder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .level(level), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoding built from field weights rather than bit concatenation.
  function automatic logic [31:0] ref_encode(int op, int rs, int rt, int rd, int sh, int imm);
    longint w;
    w = longint'(opc_tab[op]) * 64'd67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536;
    if (op <= 9)
      w = w + longint'(rd) * 2048 + ((op == 8 || op == 9) ? longint'(sh) * 64 : 0);
    else
      w = w + longint'(imm);
    return w[31:0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    chk("level", 32'(level), 32'(model_q.size()));
    chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
    chk("out_instr", out_instr, (model_q.size() != 0) ? model_q[0] : 32'h0);
    chk("err_pulse", 32'(err_pulse), 32'(model_pulse));
    chk("err_cnt", 32'(err_cnt), 32'(model_err));
  endtask

  // Drives one cycle of inputs, advances the model at the edge, then checks.
  task automatic applyStimulus(bit v, int op, int rs, int rt, int rd, int sh, int imm, bit ordy);
    bit acc, popd;
    in_valid  = v;
    in_op     = 4'(op);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_shamt  = 5'(sh);
    in_imm    = 16'(imm);
    out_ready = ordy;
    acc  = v && (model_q.size() < DEPTH);
    popd = ordy && (model_q.size() > 0);
    @(posedge clk);
    if (popd) void'(model_q.pop_front());
    if (acc && op <= 13) model_q.push_back(ref_encode(op, rs, rt, rd, sh, imm));
    model_pulse = acc && (op >= 14);
    if (acc && op >= 14 && model_err < 255) model_err++;
    #1;
    checkOutput();
  endtask

  task automatic idle(bit ordy);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    model_q.delete();
    model_err   = 0;
    model_pulse = 1'b0;
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{0,  2, 3, 1, 7, 0,      32'h04430800};
    vecs[1] = '{8,  0, 2, 1, 3, 0,      32'h240208C0};
    vecs[2] = '{13, 4, 5, 0, 0, 16'h10, 32'h90850010};
    vecs[3] = '{12, 1, 2, 0, 0, 16'hFFFF, 32'h8822FFFF};
    vecs[4] = '{7,  31, 0, 31, 31, 0,   32'h23E0F800};
    vecs[5] = '{9,  0, 0, 0, 31, 0,     32'h280007C0};
    vecs[6] = '{10, 3, 4, 0, 0, 16'h1234, 32'h2C641234};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0;
    model_err = 0; model_pulse = 1'b0;
    #3;
    checkOutput();
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, 1'b0);
      chk("vec_word", out_instr, vecs[i].word);
      chk("vec_level", 32'(level), 32'd1);
      idle(1'b1);
    end

    $display("[TB] fill and drain");
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(1'b1, i, i + 1, i + 2, i + 3, i, i * 7, 1'b0);
    chk("full_level", 32'(level), 32'(DEPTH));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 5, 1, 1, 1, 0, 0, 1'b1);
    chk("full_no_passthru", 32'(level), 32'(DEPTH - 1));
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    chk("drained_valid", 32'(out_valid), 32'd0);

    $display("[TB] steady push and pop");
    applyStimulus(1'b1, 1, 9, 9, 9, 0, 0, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      applyStimulus(1'b1, $urandom_range(0, 13), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535), 1'b1);
      chk("steady_level", 32'(level), 32'd1);
    end
    idle(1'b1);

    $display("[TB] illegal requests");
    doReset();
    applyStimulus(1'b1, 15, 1, 2, 3, 4, 5, 1'b0);
    chk("illegal_pulse", 32'(err_pulse), 32'd1);
    chk("illegal_cnt", 32'(err_cnt), 32'd1);
    chk("illegal_nowrite", 32'(out_valid), 32'd0);
    idle(1'b0);
    chk("pulse_one_cycle", 32'(err_pulse), 32'd0);
    for (int i = 0; i < 299; i++) applyStimulus(1'b1, 14 + (i % 2), 0, 0, 0, 0, 0, 1'b0);
    chk("err_saturated", 32'(err_cnt), 32'd255);
    idle(1'b0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2, i, i, i, 0, 0, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #2;
    doReset();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    applyStimulus(1'b1, 0, 2, 3, 1, 7, 0, 1'b0);
    chk("post_rst_word", out_instr, 32'h04430800);
    chk("post_rst_level", 32'(level), 32'd1);
    idle(1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++)
      applyStimulus(($urandom_range(0, 3) != 0), $urandom_range(0, 15), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 65535), ($urandom_range(0, 2) != 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
